// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture controller: FSM state
// encoding, sample width, beat packing and the constant tkeep value.
package adc_capture_pkg;

    localparam int ADC_W = 12;
    localparam logic [3:0] TKEEP_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } cap_state_t;

    // Pack a channel pair into one stream word: {4'b0, db, 4'b0, da}.
    function automatic logic [31:0] pack_beat(input logic [ADC_W-1:0] da,
                                              input logic [ADC_W-1:0] db);
        return {4'b0000, db, 4'b0000, da};
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the oldest entry.
// Full/empty come from a registered occupancy count so the full flag
// seen by the writer never depends on a same-cycle pop.
module capture_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 33,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: packs dual-channel samples into 32-bit beats,
// frames them with tlast and buffers them towards an AXI-Stream sink.
// Optional macro ADC_CAPTURE_TEST_PATTERN_EN adds cfg_test_pat, which
// replaces live samples with an incrementing counter pattern.
//
// Stream handshake: a beat transfers on a cycle where m_axis_tvalid and
// m_axis_tready are both high; tvalid never drops and tdata/tlast never
// change while a beat is waiting for tready.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16,
    parameter int NUM_W      = 16,
    parameter int OVF_W      = 16
) (
    input  logic             sys_clk,
    input  logic             ic_rst_n,
    input  logic             smp_vld,
    input  logic [11:0]      da_data,
    input  logic [11:0]      db_data,
    input  logic             ctrl_start,
    input  logic             ctrl_stop,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [NUM_W-1:0] cfg_frame_num,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    input  logic             cfg_test_pat,
`endif
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             sts_busy,
    output logic             sts_done,
    output logic             sts_ovf,
    output logic [OVF_W-1:0] sts_ovf_cnt,
    output logic [NUM_W-1:0] sts_frames,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    cap_state_t       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] frames_q, frames_d;
    logic             ovf_q, ovf_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             stop_pend_q, stop_pend_d;

    logic             push_c, done_c;
    logic             last_beat, run_end, stop_req;
    logic [ADC_W-1:0] smp_a, smp_b;

    logic [32:0]      fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));
    assign run_end   = (num_q != '0) && ((frames_q + NUM_W'(1)) == num_q);
    assign stop_req  = ctrl_stop | stop_pend_q;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    logic             pat_en_q, pat_en_d;
    logic [ADC_W-1:0] pat_q, pat_d;

    assign smp_a = pat_en_q ? pat_q : da_data;
    assign smp_b = pat_en_q ? (pat_q + ADC_W'(1)) : db_data;

    // Pattern counter restarts each run and only advances on accepted pushes.
    always_comb begin
        pat_en_d = pat_en_q;
        pat_d    = pat_q;
        if (state_q == IDLE && ctrl_start) begin
            pat_en_d = cfg_test_pat;
            pat_d    = '0;
        end else if (push_c) begin
            pat_d = pat_q + ADC_W'(2);
        end
    end

    // Pattern registers.
    always_ff @(posedge sys_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            pat_en_q <= 1'b0;
            pat_q    <= '0;
        end else begin
            pat_en_q <= pat_en_d;
            pat_q    <= pat_d;
        end
    end
`else
    assign smp_a = da_data;
    assign smp_b = db_data;
`endif

    // Run sequencing: start latches config, capture frames beats, drain
    // waits for the buffer to empty before signalling done.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        beat_cnt_d  = beat_cnt_q;
        frames_d    = frames_q;
        ovf_d       = ovf_q;
        ovf_cnt_d   = ovf_cnt_q;
        stop_pend_d = stop_pend_q;
        push_c      = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    len_d       = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
                    num_d       = cfg_frame_num;
                    beat_cnt_d  = '0;
                    frames_d    = '0;
                    ovf_d       = 1'b0;
                    ovf_cnt_d   = '0;
                    stop_pend_d = 1'b0;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (ctrl_stop) stop_pend_d = 1'b1;
                if (smp_vld) begin
                    if (!fifo_full) begin
                        push_c     = 1'b1;
                        beat_cnt_d = last_beat ? '0 : beat_cnt_q + LEN_W'(1);
                        if (last_beat) begin
                            frames_d = frames_q + NUM_W'(1);
                            if (stop_req || run_end) state_d = DRAIN;
                        end
                    end else begin
                        // Dropped samples never enter a frame.
                        ovf_d = 1'b1;
                        if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
                    end
                end
                // Stopping between frames needs no further beats.
                if (stop_req && beat_cnt_q == '0 && !push_c) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_count == '0) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge sys_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q     <= IDLE;
            len_q       <= LEN_W'(1);
            num_q       <= '0;
            beat_cnt_q  <= '0;
            frames_q    <= '0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            beat_cnt_q  <= beat_cnt_d;
            frames_q    <= frames_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (ic_rst_n),
        .push  (push_c),
        .pop   (m_axis_tvalid & m_axis_tready),
        .wdata ({last_beat, pack_beat(smp_a, smp_b)}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stream outputs read zero while nothing is buffered.
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 32'h0 : fifo_rdata[31:0];
    assign m_axis_tlast  = ~fifo_empty & fifo_rdata[32];
    assign m_axis_tkeep  = TKEEP_ALL;

    assign sts_busy    = (state_q != IDLE);
    assign sts_done    = done_c;
    assign sts_ovf     = ovf_q;
    assign sts_ovf_cnt = ovf_cnt_q;
    assign sts_frames  = frames_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed runs against a queue-based model
// of the capture rules, plus literal expectations for key beats.
module tb_adc_capture_ctrl;

    localparam int DEPTH = 16;

    logic        sys_clk = 1'b0;
    logic        ic_rst_n = 1'b0;
    logic        smp_vld = 1'b0;
    logic [11:0] da_data = '0;
    logic [11:0] db_data = '0;
    logic        ctrl_start = 1'b0;
    logic        ctrl_stop = 1'b0;
    logic [15:0] cfg_frame_len = '0;
    logic [15:0] cfg_frame_num = '0;
    logic        cfg_test_pat = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        sts_busy;
    logic        sts_done;
    logic        sts_ovf;
    logic [15:0] sts_ovf_cnt;
    logic [15:0] sts_frames;
    logic [1:0]  dbg_state;

    adc_capture_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (16),
        .NUM_W      (16),
        .OVF_W      (16)
    ) dut (
        .sys_clk       (sys_clk),
        .ic_rst_n      (ic_rst_n),
        .smp_vld       (smp_vld),
        .da_data       (da_data),
        .db_data       (db_data),
        .ctrl_start    (ctrl_start),
        .ctrl_stop     (ctrl_stop),
        .cfg_frame_len (cfg_frame_len),
        .cfg_frame_num (cfg_frame_num),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        .cfg_test_pat  (cfg_test_pat),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_ovf       (sts_ovf),
        .sts_ovf_cnt   (sts_ovf_cnt),
        .sts_frames    (sts_frames),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    logic [32:0] exp_q[$];      // beats the model says are buffered, oldest first
    logic [32:0] pop_log[$];    // beats observed leaving the DUT
    int          cyc_n = 0;
    int          last_pop_cyc = 0;
    int          done_cyc = 0;
    int          done_count = 0;

    int          m_phase = 0;   // 0 idle, 1 capturing, 2 draining
    logic [15:0] m_len = 16'd1;
    logic [15:0] m_num = '0;
    logic [15:0] m_beat = '0;
    logic [15:0] m_frames = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_ovf_cnt = '0;
    logic        m_stop = 1'b0;
    logic        m_pat_en = 1'b0;
    logic [11:0] m_pat = '0;

    task automatic model_reset();
        exp_q.delete();
        m_phase   = 0;
        m_frames  = '0;
        m_ovf     = 1'b0;
        m_ovf_cnt = '0;
        m_stop    = 1'b0;
        m_beat    = '0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_step();
        int          occ;
        logic        accepted;
        logic        stop_now;
        logic        is_last;
        logic [15:0] beat_before;
        logic [11:0] a;
        logic [11:0] b;
        occ = exp_q.size();
        if (occ > 0 && m_axis_tready) void'(exp_q.pop_front());
        if (m_phase == 0) begin
            if (ctrl_start) begin
                m_len     = (cfg_frame_len == 0) ? 16'd1 : cfg_frame_len;
                m_num     = cfg_frame_num;
                m_beat    = '0;
                m_frames  = '0;
                m_ovf     = 1'b0;
                m_ovf_cnt = '0;
                m_stop    = 1'b0;
                m_pat     = '0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
                m_pat_en  = cfg_test_pat;
`else
                m_pat_en  = 1'b0;
`endif
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            stop_now    = ctrl_stop || m_stop;
            beat_before = m_beat;
            accepted    = 1'b0;
            if (ctrl_stop) m_stop = 1'b1;
            if (smp_vld) begin
                if (occ < DEPTH) begin
                    accepted = 1'b1;
                    a = m_pat_en ? m_pat : da_data;
                    b = m_pat_en ? m_pat + 12'd1 : db_data;
                    is_last = (m_beat == m_len - 16'd1);
                    exp_q.push_back({is_last, 4'h0, b, 4'h0, a});
                    m_pat = m_pat + 12'd2;
                    if (is_last) begin
                        m_beat   = '0;
                        m_frames = m_frames + 16'd1;
                        if (stop_now || (m_num != 0 && m_frames == m_num)) m_phase = 2;
                    end else begin
                        m_beat = m_beat + 16'd1;
                    end
                end else begin
                    m_ovf = 1'b1;
                    if (m_ovf_cnt != 16'hFFFF) m_ovf_cnt = m_ovf_cnt + 16'd1;
                end
            end
            if (stop_now && beat_before == 0 && !accepted) m_phase = 2;
        end else begin
            if (occ == 0) m_phase = 0;
        end
    endtask

    task automatic compare_outputs();
        chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("tdata", m_axis_tdata, exp_q[0][31:0]);
            chk("tlast", m_axis_tlast, exp_q[0][32]);
        end else begin
            chk("tdata_empty", m_axis_tdata, 0);
            chk("tlast_empty", m_axis_tlast, 0);
        end
        chk("tkeep", m_axis_tkeep, 4'hF);
        chk("busy", sts_busy, m_phase != 0);
        chk("done", sts_done, (m_phase == 2) && (exp_q.size() == 0));
        chk("ovf", sts_ovf, m_ovf);
        chk("ovf_cnt", sts_ovf_cnt, m_ovf_cnt);
        chk("frames", sts_frames, m_frames);
    endtask

    // Compare process: checks every falling edge, then advances the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            cyc_n++;
            if (!ic_rst_n) model_reset();
            compare_outputs();
            if (m_axis_tvalid && m_axis_tready) begin
                pop_log.push_back({m_axis_tlast, m_axis_tdata});
                last_pop_cyc = cyc_n;
            end
            if (sts_done) begin
                done_count++;
                done_cyc = cyc_n;
            end
            if (ic_rst_n) model_step();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_run(input int len, input int num, input logic pat);
        pop_log.delete();
        done_count    = 0;
        cfg_frame_len = 16'(len);
        cfg_frame_num = 16'(num);
        cfg_test_pat  = pat;
        ctrl_start    = 1'b1;
        cyc();
        ctrl_start    = 1'b0;
    endtask

    task automatic send_samples(input int n, input int da0, input int db0);
        for (int i = 0; i < n; i++) begin
            smp_vld = 1'b1;
            da_data = 12'(da0 + i);
            db_data = 12'(db0 + i);
            cyc();
        end
        smp_vld = 1'b0;
    endtask

    task automatic pulse_stop();
        ctrl_stop = 1'b1;
        cyc();
        ctrl_stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!sts_busy) return;
            cyc();
        end
        n_checks++;
        n_err++;
        $display("FAIL wait_idle: still busy after %0d cycles", budget);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) cyc();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 4'hF);
        chk("rst_busy", sts_busy, 0);
        chk("rst_frames", sts_frames, 0);
        ic_rst_n = 1'b1;
        cyc();

        // Two frames of four, free-flowing sink.
        m_axis_tready = 1'b1;
        start_run(4, 2, 1'b0);
        send_samples(8, 1, 'h101);
        wait_idle(100);
        chk("s1_nbeats", pop_log.size(), 8);
        chk("s1_beat0", pop_log[0], {1'b0, 32'h01010001});
        chk("s1_beat3_last", pop_log[3], {1'b1, 32'h01040004});
        chk("s1_beat4_nolast", pop_log[4][32], 0);
        chk("s1_beat7", pop_log[7], {1'b1, 32'h01080008});
        chk("s1_frames", sts_frames, 2);
        chk("s1_done_cnt", done_count, 1);
        chk("s1_done_lat", done_cyc - last_pop_cyc, 1);

        // Stalled sink: buffer fills, four samples dropped, then drain.
        m_axis_tready = 1'b0;
        start_run(4, 0, 1'b0);
        send_samples(20, 'h20, 'h220);
        pulse_stop();
        repeat (18) cyc();
        m_axis_tready = 1'b1;
        wait_idle(100);
        chk("s2_nbeats", pop_log.size(), 16);
        for (int i = 0; i < 16; i++) chk("s2_tlast", pop_log[i][32], (i % 4) == 3);
        chk("s2_ovf", sts_ovf, 1);
        chk("s2_ovf_cnt", sts_ovf_cnt, 4);
        chk("s2_frames", sts_frames, 4);

        // Stop mid-frame: finish the frame, ignore later samples.
        start_run(3, 0, 1'b0);
        send_samples(5, 'h10, 'h310);
        pulse_stop();
        send_samples(4, 'h15, 'h315);
        wait_idle(100);
        chk("s3_nbeats", pop_log.size(), 6);
        chk("s3_beat5", pop_log[5], {1'b1, 32'h03150015});
        chk("s3_frames", sts_frames, 2);
        chk("s3_ovf", sts_ovf, 0);
        chk("s3_done_cnt", done_count, 1);

        // Stop on a frame boundary, with a start pulse while busy.
        start_run(2, 0, 1'b0);
        send_samples(2, 'h40, 'h440);
        cfg_frame_len = 16'd5;
        ctrl_start = 1'b1;
        cyc();
        ctrl_start = 1'b0;
        send_samples(2, 'h42, 'h442);
        pulse_stop();
        send_samples(2, 'h44, 'h444);
        wait_idle(100);
        chk("s4_nbeats", pop_log.size(), 4);
        chk("s4_beat1_last", pop_log[1][32], 1);
        chk("s4_beat3", pop_log[3], {1'b1, 32'h04430043});
        chk("s4_frames", sts_frames, 2);

        // Zero frame length behaves as one beat per frame.
        start_run(0, 3, 1'b0);
        send_samples(5, 'h50, 'h550);
        wait_idle(100);
        chk("s5_nbeats", pop_log.size(), 3);
        chk("s5_beat2", pop_log[2], {1'b1, 32'h05520052});
        chk("s5_frames", sts_frames, 3);

        // Reset mid-frame with five beats buffered.
        m_axis_tready = 1'b0;
        start_run(8, 0, 1'b0);
        send_samples(5, 'h60, 'h660);
        cyc();
        chk("s6_tvalid_pre", m_axis_tvalid, 1);
        ic_rst_n = 1'b0;
        #1;
        chk("s6_tvalid_rst", m_axis_tvalid, 0);
        chk("s6_busy_rst", sts_busy, 0);
        cyc();
        cyc();
        ic_rst_n = 1'b1;
        m_axis_tready = 1'b1;
        cyc();
        start_run(4, 1, 1'b0);
        chk("s6_frames_clean", sts_frames, 0);
        send_samples(4, 'h70, 'h770);
        wait_idle(100);
        chk("s6_nbeats", pop_log.size(), 4);
        chk("s6_beat0", pop_log[0], {1'b0, 32'h07700070});
        chk("s6_frames", sts_frames, 1);

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        // Counter pattern across the 12-bit wrap.
        start_run(2, 0, 1'b1);
        send_samples(2050, 'h123, 'h456);
        pulse_stop();
        wait_idle(200);
        chk("pat_nbeats", pop_log.size(), 2050);
        chk("pat_beat0", pop_log[0], {1'b0, 32'h00010000});
        chk("pat_beat1", pop_log[1], {1'b1, 32'h00030002});
        chk("pat_beat2047", pop_log[2047], {1'b1, 32'h0FFF0FFE});
        chk("pat_beat2048", pop_log[2048], {1'b0, 32'h00010000});
        cfg_test_pat = 1'b0;
`endif

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
